// File: rtl/i2c_pkg.sv
// Shared I2C definitions: responder state encoding and board sensor addresses.
// Used by the sensor responder and the polling master.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_TX_BYTE,
        ST_TX_ACK,
        ST_RX_BYTE,
        ST_RX_ACK,
        ST_WAIT_STOP
    } resp_state_t;

    localparam logic [6:0] SOLAR      = 7'h48;
    localparam logic [6:0] GREENHOUSE = 7'h49;
    localparam logic [6:0] AMBIENT    = 7'h4A;
    localparam logic [6:0] GEOTHERMAL = 7'h4B;
    localparam logic [6:0] NORTH      = 7'h44;
    localparam logic [6:0] EAST       = 7'h45;
    localparam logic [6:0] SOUTH      = 7'h46;
    localparam logic [6:0] WEST       = 7'h47;

    function automatic logic [7:0] pick_byte(logic [15:0] v, logic lsb);
        return lsb ? v[7:0] : v[15:8];
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizers with SCL edge and START/STOP detection.
// Bus lines idle high, so every flop resets to 1.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [SYNC_STAGES-1:0] scl_sr;
    logic [SYNC_STAGES-1:0] sda_sr;
    logic                   scl_q;
    logic                   sda_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sr <= '1;
            sda_sr <= '1;
            scl_q  <= 1'b1;
            sda_q  <= 1'b1;
        end else begin
            scl_sr <= {scl_sr[SYNC_STAGES-2:0], scl_in};
            sda_sr <= {sda_sr[SYNC_STAGES-2:0], sda_in};
            scl_q  <= scl;
            sda_q  <= sda;
        end
    end

    assign scl      = scl_sr[SYNC_STAGES-1];
    assign sda      = sda_sr[SYNC_STAGES-1];
    assign scl_rise = scl & ~scl_q;
    assign scl_fall = ~scl & scl_q;
    // SDA edges only count as bus events while SCL is steadily high
    assign start    = scl & scl_q & sda_q & ~sda;
    assign stop     = scl & scl_q & ~sda_q & sda;

endmodule

// File: rtl/i2c_sensor_responder.sv
// I2C target returning a 16-bit register snapshot, MSB byte first.
// Define I2C_RESP_WRITE_EN to accept 2-byte writes on wr_data/wr_valid.
module i2c_sensor_responder
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDR        = SOLAR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_out,
    input  logic [15:0] reg_data,
    output logic        rd_strobe,
    output logic [15:0] wr_data,
    output logic        wr_valid,
    output logic        busy
);

    logic scl, sda, scl_rise, scl_fall, start, stop;

    i2c_line_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .scl_in  (scl_in),
        .sda_in  (sda_in),
        .scl     (scl),
        .sda     (sda),
        .scl_rise(scl_rise),
        .scl_fall(scl_fall),
        .start   (start),
        .stop    (stop)
    );

    resp_state_t state, state_n;
    logic [3:0]  bit_cnt, bit_cnt_n;
    logic [1:0]  byte_cnt, byte_cnt_n;
    logic [7:0]  shreg, shreg_n;
    logic [15:0] snap, snap_n;
    logic        sda_q, sda_n;
    logic        rd_q, rd_n;
    logic [7:0]  rx_byte;
    logic [7:0]  tx_byte;

`ifdef I2C_RESP_WRITE_EN
    logic [7:0]  wr_b0, wr_b0_n;
    logic [15:0] wr_data_q, wr_data_n;
    logic        wr_valid_q, wr_valid_n;
`endif

    assign rx_byte = {shreg[6:0], sda};
    assign tx_byte = pick_byte(snap, byte_cnt[0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            shreg    <= '0;
            snap     <= '0;
            sda_q    <= 1'b1;
            rd_q     <= 1'b0;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            byte_cnt <= byte_cnt_n;
            shreg    <= shreg_n;
            snap     <= snap_n;
            sda_q    <= sda_n;
            rd_q     <= rd_n;
        end
    end

`ifdef I2C_RESP_WRITE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_b0      <= '0;
            wr_data_q  <= '0;
            wr_valid_q <= 1'b0;
        end else begin
            wr_b0      <= wr_b0_n;
            wr_data_q  <= wr_data_n;
            wr_valid_q <= wr_valid_n;
        end
    end
`endif

    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        byte_cnt_n = byte_cnt;
        shreg_n    = shreg;
        snap_n     = snap;
        sda_n      = sda_q;
        rd_n       = 1'b0;
`ifdef I2C_RESP_WRITE_EN
        wr_b0_n    = wr_b0;
        wr_data_n  = wr_data_q;
        wr_valid_n = 1'b0;
`endif
        if (start) begin
            state_n    = ST_ADDR;
            bit_cnt_n  = '0;
            byte_cnt_n = '0;
            sda_n      = 1'b1;
        end else if (stop) begin
            state_n = ST_IDLE;
            sda_n   = 1'b1;
        end else begin
            unique case (state)
                ST_IDLE, ST_WAIT_STOP: ;
                ST_ADDR: if (scl_rise) begin
                    shreg_n   = rx_byte;
                    bit_cnt_n = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        bit_cnt_n = '0;
                        state_n   = ST_WAIT_STOP;
                        if (rx_byte[7:1] == ADDR && rx_byte[0]) begin
                            state_n = ST_ADDR_ACK;
                            snap_n  = reg_data;
                            rd_n    = 1'b1;
                        end
`ifdef I2C_RESP_WRITE_EN
                        if (rx_byte[7:1] == ADDR && !rx_byte[0])
                            state_n = ST_ADDR_ACK;
`endif
                    end
                end
                // ACK runs from the 8th fall; leaving on the 9th rise lets
                // the next state own the 9th fall (first data bit or release)
                ST_ADDR_ACK: begin
                    if (scl_fall)
                        sda_n = 1'b0;
                    else if (scl_rise)
                        state_n = shreg[0] ? ST_TX_BYTE : ST_RX_BYTE;
                end
                ST_TX_BYTE: if (scl_fall) begin
                    if (bit_cnt == 4'd8) begin
                        sda_n   = 1'b1;
                        state_n = ST_TX_ACK;
                    end else begin
                        sda_n     = tx_byte[3'd7 - bit_cnt[2:0]];
                        bit_cnt_n = bit_cnt + 4'd1;
                    end
                end
                ST_TX_ACK: if (scl_rise) begin
                    bit_cnt_n = '0;
                    if (!sda) begin
                        state_n    = ST_TX_BYTE;
                        byte_cnt_n = {1'b0, ~byte_cnt[0]};
                    end else begin
                        state_n = ST_WAIT_STOP;
                    end
                end
`ifdef I2C_RESP_WRITE_EN
                ST_RX_BYTE: begin
                    if (scl_fall)
                        sda_n = 1'b1;
                    if (scl_rise) begin
                        shreg_n   = rx_byte;
                        bit_cnt_n = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt_n = '0;
                            state_n   = ST_RX_ACK;
                        end
                    end
                end
                ST_RX_ACK: begin
                    if (scl_fall) begin
                        sda_n = byte_cnt[1];
                    end else if (scl_rise) begin
                        if (byte_cnt[1]) begin
                            state_n = ST_WAIT_STOP;
                        end else begin
                            state_n    = ST_RX_BYTE;
                            byte_cnt_n = byte_cnt + 2'd1;
                            if (byte_cnt[0]) begin
                                wr_data_n  = {wr_b0, shreg};
                                wr_valid_n = 1'b1;
                            end else begin
                                wr_b0_n = shreg;
                            end
                        end
                    end
                end
`else
                ST_RX_BYTE, ST_RX_ACK: state_n = ST_WAIT_STOP;
`endif
                default: state_n = ST_IDLE;
            endcase
        end
    end

    assign sda_out   = sda_q;
    assign rd_strobe = rd_q;
    assign busy      = (state != ST_IDLE);

`ifdef I2C_RESP_WRITE_EN
    assign wr_data  = wr_data_q;
    assign wr_valid = wr_valid_q;
`else
    assign wr_data  = '0;
    assign wr_valid = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_sensor_responder.sv
// Bench: bit-level I2C master driving the responder, checked against a
// byte-level model of address match, snapshot order and write capture.
`timescale 1ns/1ps
module tb_i2c_sensor_responder;
    import i2c_pkg::*;

    localparam int Q = 10;
`ifdef I2C_RESP_WRITE_EN
    localparam bit WEN = 1'b1;
`else
    localparam bit WEN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic [15:0] reg_data = '0;
    logic        sda_out, rd_strobe, wr_valid, busy;
    logic [15:0] wr_data;
    wire         sda_bus = sda_m & sda_out;

    int checks = 0, passed = 0, fails = 0;
    int rd_cnt = 0, wv_cnt = 0, low_cnt = 0, viol = 0;
    logic prev_sda = 1'b1;
    logic [15:0] exp_wr = '0;

    always #5 clk = ~clk;

    i2c_sensor_responder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_in   (scl_m),
        .sda_in   (sda_bus),
        .sda_out  (sda_out),
        .reg_data (reg_data),
        .rd_strobe(rd_strobe),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .busy     (busy)
    );

    always @(negedge clk) begin
        if (rd_strobe) rd_cnt++;
        if (wr_valid) wv_cnt++;
        if (!sda_out) low_cnt++;
        if (prev_sda && !sda_out && scl_m) viol++;
        prev_sda = sda_out;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(logic [15:0] v, int i);
        logic [15:0] t;
        t = v;
        return (i % 2 == 0) ? t[15:8] : t[7:0];
    endfunction

    task automatic q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; q();
        scl_m = 1'b1; q();
        sda_m = 1'b0; q();
        scl_m = 1'b0; q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; q();
        scl_m = 1'b1; q();
        sda_m = 1'b1; q();
    endtask

    task automatic put_bit(input logic b);
        sda_m = b; q();
        scl_m = 1'b1; q(); q();
        scl_m = 1'b0; q();
    endtask

    task automatic get_bit(output logic b);
        sda_m = 1'b1; q();
        scl_m = 1'b1; q();
        b = sda_bus; q();
        scl_m = 1'b0; q();
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(ack);
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic nack);
        logic t;
        for (int i = 7; i >= 0; i--) begin
            get_bit(t);
            d[i] = t;
        end
        put_bit(nack);
    endtask

    task automatic do_read(input string tag, input logic [6:0] a,
                           input logic [15:0] v, input logic [15:0] v2,
                           input int n);
        logic ack;
        logic [7:0] b;
        int base;
        bit hit;
        base = rd_cnt;
        reg_data = v;
        hit = (a == SOLAR);
        i2c_start();
        send_byte({a, 1'b1}, ack);
        chk({tag, "_aack"}, 32'(ack), 32'(!hit));
        if (hit) begin
            for (int i = 0; i < n; i++) begin
                recv_byte(b, 1'(i == n - 1));
                chk($sformatf("%s_b%0d", tag, i), 32'(b), 32'(exp_byte(v, i)));
                reg_data = v2;
            end
        end
        chk({tag, "_busy_on"}, 32'(busy), 32'd1);
        i2c_stop(); q();
        chk({tag, "_strobe"}, 32'(rd_cnt - base), 32'(hit));
        chk({tag, "_busy_off"}, 32'(busy), 32'd0);
    endtask

    task automatic do_write(input string tag, input logic [6:0] a,
                            input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input int n);
        logic ack;
        logic [7:0] d [3];
        int base;
        bit hit;
        d[0] = d0; d[1] = d1; d[2] = d2;
        base = wv_cnt;
        hit = (a == SOLAR) && WEN;
        i2c_start();
        send_byte({a, 1'b0}, ack);
        chk({tag, "_aack"}, 32'(ack), 32'(!hit));
        if (hit) begin
            for (int i = 0; i < n; i++) begin
                send_byte(d[i], ack);
                chk($sformatf("%s_dack%0d", tag, i), 32'(ack), 32'(i >= 2));
            end
        end
        i2c_stop(); q();
        if (hit && n >= 2) exp_wr = {d[0], d[1]};
        chk({tag, "_wvalid"}, 32'(wv_cnt - base), 32'(hit && n >= 2));
        chk({tag, "_wdata"}, 32'(wr_data), 32'(exp_wr));
        chk({tag, "_busy_off"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic ack;
        logic [7:0] b;
        logic [6:0] addrs [8];
        int base;
        addrs = '{SOLAR, GREENHOUSE, AMBIENT, GEOTHERMAL,
                  NORTH, EAST, SOUTH, WEST};

        repeat (3) @(negedge clk);
        chk("rst_sda", 32'(sda_out), 32'd1);
        chk("rst_rd", 32'(rd_strobe), 32'd0);
        chk("rst_wv", 32'(wr_valid), 32'd0);
        chk("rst_wdata", 32'(wr_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        q();

        do_read("t1", SOLAR, 16'h1900, 16'h1900, 2);

        base = low_cnt;
        i2c_start();
        send_byte({GREENHOUSE, 1'b1}, ack);
        chk("t2_aack", 32'(ack), 32'd1);
        recv_byte(b, 1'b0);
        chk("t2_byte", 32'(b), 32'hFF);
        chk("t2_busy_on", 32'(busy), 32'd1);
        i2c_stop(); q();
        chk("t2_never_low", 32'(low_cnt - base), 32'd0);
        chk("t2_busy_off", 32'(busy), 32'd0);

        do_read("t3", SOLAR, 16'hABCD, 16'h0000, 4);

        do_write("t4", SOLAR, 8'h12, 8'h34, 8'h56, 3);

        i2c_start();
        for (int i = 7; i >= 0; i--) begin
            b = {SOLAR, 1'b1};
            put_bit(b[i]);
        end
        chk("t5_ack_low", 32'(sda_out), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_sda", 32'(sda_out), 32'd1);
        chk("t5_async_busy", 32'(busy), 32'd0);
        sda_m = 1'b1;
        scl_m = 1'b1;
        q();
        rst_n = 1'b1;
        q();
        do_read("t5_after", SOLAR, 16'h2468, 16'h1357, 2);

        base = rd_cnt;
        reg_data = 16'h5A3C;
        i2c_start();
        send_byte({SOLAR, 1'b1}, ack);
        chk("t6_aack1", 32'(ack), 32'd0);
        recv_byte(b, 1'b1);
        chk("t6_first", 32'(b), 32'h5A);
        reg_data = 16'hC3E1;
        i2c_start();
        send_byte({SOLAR, 1'b1}, ack);
        chk("t6_aack2", 32'(ack), 32'd0);
        recv_byte(b, 1'b0);
        chk("t6_msb", 32'(b), 32'hC3);
        recv_byte(b, 1'b1);
        chk("t6_lsb", 32'(b), 32'hE1);
        i2c_stop(); q();
        chk("t6_strobes", 32'(rd_cnt - base), 32'd2);

        for (int k = 0; k < 8; k++) begin
            logic [6:0] a;
            logic [15:0] v;
            a = ($urandom_range(0, 1) == 0) ? SOLAR : addrs[$urandom_range(0, 7)];
            v = 16'($urandom);
            if ($urandom_range(0, 1) == 1)
                do_read($sformatf("r%0d", k), a, v, 16'($urandom),
                        int'($urandom_range(1, 4)));
            else
                do_write($sformatf("w%0d", k), a, v[15:8], v[7:0],
                         8'($urandom), int'($urandom_range(1, 3)));
        end

        chk("sda_low_scl_high", 32'(viol), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
